// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with byte/half/word access, sign/zero
// extended registered loads, misalignment flagging and optional post-reset zero-fill.
module data_memory_sized #(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = $clog2(DEPTH) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              misaligned,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             fill_we;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       ofs;
  logic             aligned;
  logic             ld, st_we, err;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic [31:0]      word, shifted, ext;

  // Fill sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? FILL : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fill_we   = 1'b0;
    unique case (state)
      FILL: begin
        fill_we = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: ;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL);

  // Request decode
  always_comb begin
    idx = address[ADDR_W-1:2];
    ofs = address[1:0];
    unique case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ofs[0];
      2'b10:   aligned = (ofs == 2'b00);
      default: aligned = 1'b0;
    endcase
    ld    = mem_read & ~busy;
    st_we = mem_write & ~busy & aligned;
    err   = (mem_read | mem_write) & ~busy & ~aligned;
  end

  // Lane enables and replicated store data so each lane sees its own bytes
  always_comb begin
    be    = 4'b0000;
    wlane = write_data;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << ofs;
        wlane = {4{write_data[7:0]}};
      end
      2'b01: begin
        be    = ofs[1] ? 4'b1100 : 4'b0011;
        wlane = {2{write_data[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt] <= '0;
    end else if (st_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  // Load path reads pre-store contents, giving read-before-write on collisions
  always_comb begin
    word    = mem[idx];
    shifted = word >> {ofs, 3'b000};
    unique case (size)
      2'b00:   ext = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      read_valid <= ld;
      misaligned <= err;
      if (ld) read_data <= aligned ? ext : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: stimulus pushes expected strobes into a
// scoreboard queue, a negedge monitor pops and compares whenever a strobe appears.
module tb_data_memory_sized;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_read, mem_write, load_unsigned;
  logic [1:0]        size;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              read_valid, misaligned, busy;

  data_memory_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .address(address),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .misaligned(misaligned), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        rv;
    logic        mis;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errs    = 0;

  always @(negedge clk) begin
    if (read_valid || misaligned) begin
      vectors++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL spurious_strobe: got rv=%0b mis=%0b data=%h, required no strobe",
                 read_valid, misaligned, read_data);
      end else begin
        mon_e = sb.pop_front();
        if (read_valid !== mon_e.rv || misaligned !== mon_e.mis ||
            (mon_e.rv && read_data !== mon_e.data)) begin
          errs++;
          $display("FAIL %s: got rv=%0b mis=%0b data=%h, required rv=%0b mis=%0b data=%h",
                   mon_e.name, read_valid, misaligned, read_data, mon_e.rv, mon_e.mis, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, got, expv);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    mem_read = r; mem_write = w; size = sz; load_unsigned = u;
    address = a; write_data = d;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sz, input logic u, input logic [ADDR_W-1:0] a,
                    input logic [31:0] expv, input logic mis, input string name);
    exp_t e;
    e.data = mis ? 32'h0 : expv; e.rv = 1'b1; e.mis = mis; e.name = name;
    sb.push_back(e);
    drive(1'b1, 1'b0, sz, u, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] sz, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                    input logic mis, input string name);
    exp_t e;
    if (mis) begin
      e.data = 32'h0; e.rv = 1'b0; e.mis = 1'b1; e.name = name;
      sb.push_back(e);
    end
    drive(1'b0, 1'b1, sz, 1'b0, a, d);
  endtask

  task automatic count_busy(input string name, output int k);
    k = 0;
    while (busy && k < 200) begin
      mem_read = 1'b0; mem_write = 1'b0;
      if (k == 10) begin  // store into an already-cleared word while busy
        mem_write = 1'b1; size = SZ_W; address = 8'h00; write_data = 32'hFFFF_FFFF;
      end
      if (k == 12) begin
        mem_read = 1'b1; size = SZ_W; address = 8'h14; load_unsigned = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    check(name, 32'(k), 32'd64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = SZ_W;
    load_unsigned = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", 32'(read_valid), 32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);

    // Test 1: fill length, cleared contents, busy-time requests ignored
    rst_n = 1'b1;
    count_busy("busy_cycles_first", k);
    rd(SZ_W, 1'b0, 8'h14, 32'h0000_0000, 1'b0, "t1_word_0x14");
    rd(SZ_W, 1'b0, 8'h00, 32'h0000_0000, 1'b0, "t1_busy_write_ignored");

    // Test 2
    wr(SZ_W, 8'h08, 32'h1234_5678, 1'b0, "t2_store");
    rd(SZ_W, 1'b0, 8'h08, 32'h1234_5678, 1'b0, "t2_word_load");

    // Test 3: byte lane store and extensions
    wr(SZ_B, 8'h09, 32'h0000_00AB, 1'b0, "t3_store");
    rd(SZ_B, 1'b0, 8'h09, 32'hFFFF_FFAB, 1'b0, "t3_byte_signed");
    rd(SZ_B, 1'b1, 8'h09, 32'h0000_00AB, 1'b0, "t3_byte_unsigned");
    rd(SZ_W, 1'b0, 8'h08, 32'h1234_AB78, 1'b0, "t3_word_merge");
    rd(SZ_H, 1'b0, 8'h0A, 32'h0000_1234, 1'b0, "t3_half_signed_pos");
    wr(SZ_H, 8'h12, 32'h0000_8001, 1'b0, "t3_half_store");
    rd(SZ_H, 1'b0, 8'h12, 32'hFFFF_8001, 1'b0, "t3_half_signed_neg");
    rd(SZ_H, 1'b1, 8'h12, 32'h0000_8001, 1'b0, "t3_half_unsigned");
    rd(SZ_B, 1'b0, 8'h13, 32'hFFFF_FF80, 1'b0, "t3_byte_lane3");
    rd(SZ_W, 1'b0, 8'h10, 32'h8001_0000, 1'b0, "t3_word_upper_half");

    // Test 4: misalignment, back-to-back strobes
    rd(SZ_H, 1'b0, 8'h09, 32'h0, 1'b1, "t4_half_misaligned_load");
    wr(SZ_W, 8'h0A, 32'hDEAD_BEEF, 1'b1, "t4_word_misaligned_store");
    wr(SZ_H, 8'h0B, 32'h0000_CAFE, 1'b1, "t4_half_misaligned_store");
    wr(SZ_R, 8'h08, 32'h5555_5555, 1'b1, "t4_reserved_store");
    rd(SZ_W, 1'b0, 8'h08, 32'h1234_AB78, 1'b0, "t4_word_unchanged");
    rd(SZ_R, 1'b0, 8'h08, 32'h0, 1'b1, "t4_reserved_load");

    // Test 5: read-before-write
    wr(SZ_W, 8'h0C, 32'h1111_1111, 1'b0, "t5_store");
    begin
      exp_t e;
      e.data = 32'h1111_1111; e.rv = 1'b1; e.mis = 1'b0; e.name = "t5_rbw_old";
      sb.push_back(e);
      drive(1'b1, 1'b1, SZ_W, 1'b0, 8'h0C, 32'h2222_2222);
    end
    rd(SZ_W, 1'b0, 8'h0C, 32'h2222_2222, 1'b0, "t5_rbw_new");
    repeat (2) @(posedge clk);
    #1;
    check("hold_read_data", read_data, 32'h2222_2222);
    check("hold_read_valid_low", 32'(read_valid), 32'd0);

    // Test 6: reset pulse mid-fill restarts from word 0
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    check("midfill_busy_after_pulse", 32'(busy), 32'd1);
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("busy_cycles_restart", 32'(k), 32'd64);
    for (int unsigned w = 0; w < DEPTH; w++)
      rd(SZ_W, 1'b0, ADDR_W'(w * 4), 32'h0, 1'b0, "t6_cleared_word");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Parametrised successor to the single-size word data memory. Byte-addressed, little-endian data memory with byte/half/word loads and stores, sign or zero extension on loads, and a registered read with a valid strobe. Misaligned accesses are flagged instead of silently corrupting memory. An optional post-reset zero-fill sequencer clears the array. Sits in the MEM stage of the datapath between the ALU address output and the write-back mux.

Parameters:
DEPTH, 64, number of 32-bit words in the array (power of two, >= 2)
ADDR_W, log2(DEPTH)+2, byte-address width; the top ADDR_W-2 bits are the word index and bits [1:0] are the byte offset
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = no fill, busy never asserts

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  load request, sampled at posedge
mem_write  input  1  store request, sampled at posedge
size  input  2  00 byte, 01 half, 10 word, 11 reserved
load_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads
address  input  ADDR_W  byte address
write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
read_data  output  32  extended load result, registered
read_valid  output  1  one-cycle strobe; read_data is valid while high
misaligned  output  1  one-cycle strobe: the previous-cycle request was misaligned or had a reserved size
busy  output  1  zero-fill in progress; requests are ignored while high

Behaviour:
- Reset (async assert): read_data=0, read_valid=0, misaligned=0, busy=CLEAR_ON_RESET, fill counter=0. Array contents are not reset directly.
- FSM states: FILL and IDLE. Reset enters FILL if CLEAR_ON_RESET=1, otherwise IDLE.
- FILL: each cycle writes 0 to word[counter] and increments the counter. After writing word DEPTH-1, the next state is IDLE and busy drops. Busy is high for exactly DEPTH cycles after reset release.
- Reset asserted mid-fill restarts the fill from word 0.
- While busy=1, mem_read and mem_write are ignored: no array change, no read_valid, no misaligned.
- Alignment check (IDLE only): byte is always aligned. Half requires address[0]=0. Word requires address[1:0]=00. Size 11 is always an error.
- Error case: a request with mem_read or mem_write set that fails the check causes misaligned=1 on the next cycle and no array write.
  - If mem_read was set, read_valid=1 on that same cycle with read_data=0, so the requester never stalls.
- Store (aligned): at the posedge, write the selected lanes. A byte goes to lane address[1:0]. A half goes to lanes {address[1],0} and {address[1],1}. A word goes to all four lanes. Unselected lanes are unchanged.
- Load (aligned): 1-cycle latency. At the posedge after the request, read_valid=1 and read_data holds the extracted lane(s).
  - Extended to 32 bits with zeros if load_unsigned=1, otherwise with the sign of the MSB of the extracted field.
- read_valid and misaligned are high for exactly one cycle per request. Back-to-back requests give back-to-back strobes.
- read_data holds its last value while read_valid=0.
- mem_read and mem_write in the same cycle to the same word: read-before-write. The load returns the pre-store contents, and the store takes effect for subsequent requests.
- Address width exactly covers DEPTH words, so no out-of-range case exists.

Test Plan:
1. Release rst_n with CLEAR_ON_RESET=1, DEPTH=64 -> busy=1 for exactly 64 cycles. A word read at address 0x14 issued after busy falls -> read_valid=1 and read_data=0x00000000 next cycle. A write issued while busy -> no effect.
2. Word store 0x12345678 to address 0x08, then word load from 0x08 -> read_valid=1 and read_data=0x12345678 one cycle after the load.
3. Byte store 0xAB to 0x09. Then signed byte load from 0x09 -> 0xFFFFFFAB. Unsigned byte load -> 0x000000AB. Word load from 0x08 -> 0x1234AB78. Signed half load from 0x0A -> 0x00001234.
4. Half load from 0x09 -> misaligned=1, read_valid=1, read_data=0. Word store 0xDEADBEEF to 0x0A -> misaligned=1, and a later word load from 0x08 still returns 0x1234AB78. Size=11 byte load -> misaligned=1.
5. Word 0x0C holds 0x11111111. Simultaneous mem_read and mem_write of 0x22222222 to 0x0C -> read_data=0x11111111. The next load returns 0x22222222.
6. Pulse rst_n low at fill cycle 30 -> busy stays high for 64 further cycles after release, and all words read back as 0.
